id_ex_stage: RTL and testbench

//  ID/EX pipeline register fed by the decoder's control bundle and the register-file/immediate datapath.

---
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble/flush handling
// and a halt-drain FSM that raises halted once the back end has emptied.
module id_ex_stage #(
    parameter int DATA_W       = 32,
    parameter int CTRL_W       = 18,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic [5:0]        id_funct,
    input  logic [5:0]        id_opcode,
    input  logic              flush,
    input  logic              ex_stall,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_funct,
    output logic [5:0]        ex_opcode,
    output logic              freeze,
    output logic              load_use,
    output logic              halted
);

    localparam int PC_END   = CTRL_W - 1;
    localparam int MEM_READ = CTRL_W - 5;
    localparam int CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
        logic [5:0]        opcode;
    } ex_t;

    ex_t              ex_q, ex_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             capture;

    // r0 is hardwired, so a load targeting it never creates a hazard
    assign load_use = ex_q.valid & ex_q.ctrl[MEM_READ] & (ex_q.rt != 5'd0)
                    & id_valid & ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));

    assign freeze  = load_use | ex_stall | (state_q != RUN);
    assign capture = ~flush & ~ex_stall & ~load_use & (state_q == RUN);

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (load_use || state_q != RUN) begin
            ex_d = '0;
        end else begin
            ex_d.valid   = id_valid;
            ex_d.ctrl    = id_valid ? id_ctrl : '0;
            ex_d.pc      = id_pc;
            ex_d.rs_data = id_rs_data;
            ex_d.rt_data = id_rt_data;
            ex_d.imm     = id_imm;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.rd      = id_rd;
            ex_d.shamt   = id_shamt;
            ex_d.funct   = id_funct;
            ex_d.opcode  = id_opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (capture && id_valid && id_ctrl[PC_END]) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                // an older taken branch squashes the halt still in flight
                if (flush) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (!ex_stall) begin
                    if (cnt_q == CNT_LAST) state_d = HALTED;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
            end
            HALTED: state_d = HALTED;
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q     <= '0;
            state_q  <= RUN;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign ex_valid   = ex_q.valid;
    assign ex_ctrl    = ex_q.ctrl;
    assign ex_pc      = ex_q.pc;
    assign ex_rs_data = ex_q.rs_data;
    assign ex_rt_data = ex_q.rt_data;
    assign ex_imm     = ex_q.imm;
    assign ex_rs      = ex_q.rs;
    assign ex_rt      = ex_q.rt;
    assign ex_rd      = ex_q.rd;
    assign ex_shamt   = ex_q.shamt;
    assign ex_funct   = ex_q.funct;
    assign ex_opcode  = ex_q.opcode;
    assign halted     = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: pass-through, hazards,
// flush/stall priority and halt drain/squash sequences.
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int CW = 18;

    localparam logic [CW-1:0] C_ADDI = 18'h08004;
    localparam logic [CW-1:0] C_LW   = 18'h1A004;
    localparam logic [CW-1:0] C_ADD  = 18'h08012;
    localparam logic [CW-1:0] C_HALT = 18'h20000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          id_valid;
    logic [CW-1:0] id_ctrl;
    logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]    id_funct, id_opcode;
    logic          flush, ex_stall;
    logic          ex_valid;
    logic [CW-1:0] ex_ctrl;
    logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]    ex_funct, ex_opcode;
    logic          freeze, load_use, halted;

    int n_vec = 0;
    int n_bad = 0;

    id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_opcode(id_opcode),
        .flush(flush), .ex_stall(ex_stall),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_opcode(ex_opcode),
        .freeze(freeze), .load_use(load_use), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] pc;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [DW-1:0] imm;
        logic          fl;
        logic          st;
        logic          e_lu;
        logic          e_fz;
        logic          e_v;
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_pc;
        logic [DW-1:0] e_imm;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // side-band fields are derived from the PC so captures can be checked
    task automatic drive(input logic v, input logic [CW-1:0] c,
                         input logic [DW-1:0] pc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [DW-1:0] imm,
                         input logic fl, input logic st);
        id_valid   = v;
        id_ctrl    = c;
        id_pc      = pc;
        id_rs      = rs;
        id_rt      = rt;
        id_imm     = imm;
        id_rs_data = pc ^ 32'hA5A5_0000;
        id_rt_data = pc ^ 32'h5A5A_0000;
        id_rd      = pc[4:0];
        id_shamt   = pc[6:2];
        id_funct   = pc[7:2];
        id_opcode  = pc[8:3];
        flush      = fl;
        ex_stall   = st;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic halt_run(input int stall_edge, input int exp_edges);
        int n;
        n = 0;
        @(negedge clk);
        drive(1'b1, C_HALT, 32'h40, 5'd0, 5'd0, '0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("halt_in_ex", {ex_valid, ex_ctrl}, {1'b1, C_HALT});
        while (!halted && n < 10) begin
            @(negedge clk);
            drive(1'b1, C_ADDI, 32'h44, 5'd1, 5'd2, 32'd1, 1'b0,
                  (n + 1 == stall_edge));
            #1;
            if (freeze !== 1'b1) chk("drain_freeze", freeze, 1);
            @(posedge clk);
            #1;
            n++;
        end
        chk("halt_latency", n, exp_edges);
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1, C_ADDI, 32'h08, 0, 3, 5,     0, 0, 0, 0, 1, C_ADDI, 32'h08, 5};
        tbl[1]  = '{1, C_LW,   32'h0C, 1, 4, 32'h10, 0, 0, 0, 0, 1, C_LW,  32'h0C, 32'h10};
        tbl[2]  = '{1, C_ADD,  32'h10, 4, 5, 0,     0, 0, 1, 1, 0, 0,      0,      0};
        tbl[3]  = '{1, C_ADD,  32'h10, 4, 5, 0,     0, 0, 0, 0, 1, C_ADD,  32'h10, 0};
        tbl[4]  = '{1, C_LW,   32'h14, 2, 0, 32'h8, 0, 0, 0, 0, 1, C_LW,   32'h14, 32'h8};
        tbl[5]  = '{1, C_ADD,  32'h18, 0, 0, 0,     0, 0, 0, 0, 1, C_ADD,  32'h18, 0};
        tbl[6]  = '{1, C_LW,   32'h1C, 2, 6, 32'h20, 0, 0, 0, 0, 1, C_LW,  32'h1C, 32'h20};
        tbl[7]  = '{1, C_ADD,  32'h20, 1, 6, 0,     0, 1, 1, 1, 1, C_LW,   32'h1C, 32'h20};
        tbl[8]  = '{1, C_ADD,  32'h20, 1, 6, 0,     1, 1, 1, 1, 0, 0,      0,      0};
        tbl[9]  = '{0, C_ADD,  32'h24, 1, 6, 0,     0, 0, 0, 0, 0, 0,      32'h24, 0};
        tbl[10] = '{1, C_ADDI, 32'h28, 0, 7, 7,     0, 0, 0, 0, 1, C_ADDI, 32'h28, 7};
        tbl[11] = '{1, C_ADDI, 32'h2C, 0, 7, 9,     1, 0, 0, 0, 0, 0,      0,      0};

        // reset with an all-ones control bundle sitting in ID
        reset_n = 1'b0;
        drive(1'b1, '1, 32'hFFFF_FFFF, 5'd1, 5'd1, '1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ex_valid, 0);
        chk("rst_ctrl", ex_ctrl, 0);
        chk("rst_halted", halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_freeze", freeze, 0);

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ctrl, tbl[i].pc, tbl[i].rs, tbl[i].rt,
                  tbl[i].imm, tbl[i].fl, tbl[i].st);
            #1;
            chk($sformatf("v%0d_load_use", i), load_use, tbl[i].e_lu);
            chk($sformatf("v%0d_freeze", i), freeze, tbl[i].e_fz);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), ex_valid, tbl[i].e_v);
            chk($sformatf("v%0d_ctrl", i), ex_ctrl, tbl[i].e_ctrl);
            chk($sformatf("v%0d_pc", i), ex_pc, tbl[i].e_pc);
            chk($sformatf("v%0d_imm", i), ex_imm, tbl[i].e_imm);
            chk($sformatf("v%0d_data", i),
                {ex_rs_data, ex_rt_data},
                (tbl[i].e_pc == 0) ? 64'd0 :
                {tbl[i].e_pc ^ 32'hA5A5_0000, tbl[i].e_pc ^ 32'h5A5A_0000});
            chk($sformatf("v%0d_side", i),
                {ex_rd, ex_shamt, ex_funct, ex_opcode},
                {tbl[i].e_pc[4:0], tbl[i].e_pc[6:2], tbl[i].e_pc[7:2],
                 tbl[i].e_pc[8:3]});
            chk($sformatf("v%0d_halted", i), halted, 0);
        end

        // halt drains in exactly three edges, then ignores flush
        do_reset();
        halt_run(0, 3);
        chk("halted_freeze", freeze, 1);
        @(negedge clk);
        drive(1'b1, C_ADDI, 32'h50, 5'd0, 5'd1, 32'd1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("halted_flush_ignored", halted, 1);
        chk("halted_bubble", {ex_valid, ex_ctrl}, 0);

        // asynchronous reset drops halted mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_halted", halted, 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("async_rst_freeze", freeze, 0);

        // a single stall during drain adds one edge
        do_reset();
        halt_run(1, 4);

        // flush right after the halt is captured squashes it
        do_reset();
        @(negedge clk);
        drive(1'b1, C_HALT, 32'h60, 5'd0, 5'd0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, C_ADDI, 32'h64, 5'd0, 5'd2, 32'd3, 1'b1, 1'b0);
        #1;
        chk("squash_freeze_pre", freeze, 1);
        @(posedge clk);
        #1;
        chk("squash_bubble", ex_valid, 0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        #1;
        chk("squash_freeze", freeze, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("squash_halted%0d", k), halted, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
